motion_bbox_extract: RTL
========================

# motion_bbox_extract

Per-frame motion bounding-box extractor placed directly downstream of the frame-difference stage. It consumes the 1-bit motion mask stream (vsync/href/clken + bit), tracks column/row position, and accumulates min/max X/Y and the count of motion pixels over each frame. At each frame boundary it publishes the box, the count and a noise-gated valid flag for the overlay/tracking logic.

## Interface
Parameters:
- IMG_W, 640, active pixels per line; columns at or beyond IMG_W are ignored
- IMG_H, 480, active lines per frame; rows at or beyond IMG_H are ignored
- X_W, 11, column/coordinate width (must satisfy 2^X_W > IMG_W)
- Y_W, 10, row/coordinate width (must satisfy 2^Y_W > IMG_H)
- CNT_W, 20, motion-pixel counter width

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- per_frame_vsync  in  1  frame sync from frame-difference stage, high = vertical blanking
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel strobe
- per_img_Bit  in  1  motion bit (1 = motion)
- Min_Pixel_Cnt  in  CNT_W  noise threshold, sampled at frame close
- box_x_min / box_x_max  out  X_W  box columns, inclusive
- box_y_min / box_y_max  out  Y_W  box rows, inclusive
- box_pix_cnt  out  CNT_W  motion pixels in the last closed frame
- box_valid  out  1  last closed frame had box_pix_cnt >= Min_Pixel_Cnt and >= 1
- box_update  out  1  one-cycle pulse when outputs change

## Operation
- Pixel event = per_frame_href & per_frame_clken & !per_frame_vsync. Motion event = pixel event & per_img_Bit & col < IMG_W & row < IMG_H.
- Column counter col (X_W): cleared on href falling edge and at frame open. Increments by 1 per pixel event and saturates at 2^X_W-1.
- Row counter row (Y_W): cleared at frame open. Increments on each href falling edge (1→0 of registered href) and saturates at 2^Y_W-1.
- Accumulators: x_min and y_min init all-ones; x_max and y_max init 0; cnt init 0; found init 0.
- On a motion event: min/max update with the current col/row, cnt increments (saturating at 2^CNT_W-1), and found is set.
- Frame close/open = vsync rising edge (sampled high, previous sample low).
- FSM has two states:
  - WAIT_FRAME (reset state): ignores all pixels. On the first vsync rising edge it clears the accumulators and goes to ACCUM. No box_update is issued.
  - ACCUM: accumulates. On each vsync rising edge it latches the outputs, pulses box_update, clears the accumulators and counters, and stays in ACCUM.
- Latch rule:
  - valid = found & (cnt >= Min_Pixel_Cnt).
  - If valid, publish the box and count.
  - Else publish all coordinates = 0 and box_valid = 0, while box_pix_cnt still shows the true cnt.
- Min_Pixel_Cnt = 0 behaves as 1 (valid requires found).

## Timing
- Reset values: all outputs 0; FSM in WAIT_FRAME; accumulators in their init values; vsync/href edge registers 0.
- Edge k is the first edge sampling vsync=1 after a 0 sample. Outputs and box_update=1 are visible after edge k+1. box_update drops after edge k+2.
- A motion event sampled at edge j affects the accumulators after edge j+1. A pixel present on the same edge as the vsync rise is ignored (vsync gate).
- Outputs hold between updates. href high during vsync is ignored.
- Reset asserted mid-frame: everything returns to reset values the next edge. The partial frame is discarded, and the first update comes at the second vsync rise after reset release.
- Throughput: one pixel per cycle; back-to-back clken is legal.

## Structure
- Shared package `motion_bbox_pkg`: FSM state enum (WAIT_FRAME, ACCUM) and the accumulator init constants.
- One natural sub-module: `sync_edge_det` (registered rising/falling detect). It is instantiated for vsync and href.
- Everything else lives in a single always block set in this module.

## Test plan
Run with IMG_W=8, IMG_H=4, Min_Pixel_Cnt=2.
- Reset, then frame A (discarded) and frame B with motion at (2,1) and (5,3): at the next vsync rise, box_update pulses once with x 2..5, y 1..3, cnt=2, box_valid=1.
- Frame with a single motion pixel at (0,0): box_pix_cnt=1, box_valid=0, all coordinates 0.
- Frame of all motion bits with 10 clken per line (cols 8,9 out of range) and 6 lines: box x 0..7, y 0..3, cnt=32, valid=1.
- Motion bit with clken=0 or href=0, plus one clken pulse coincident with the vsync rise: none counted, cnt=0, valid=0.
- Assert sys_rst for 1 cycle mid-frame after 3 motion pixels: outputs become 0 immediately. The next vsync rise gives no update; the following one reports only the new frame.
- Min_Pixel_Cnt changed from 2 to 0 mid-frame with one motion pixel: the value sampled at close applies, so box_valid=1.

Source files
------------

// File: rtl/motion_bbox_pkg.sv
// Shared types and init constants for the motion bounding-box extractor.
package motion_bbox_pkg;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    // Truncated to the coordinate/count width at the point of use.
    localparam logic [31:0] MIN_INIT = '1;
    localparam logic [31:0] MAX_INIT = '0;

endpackage

// File: rtl/motion_bbox_extract_sync_edge_det.sv
// Registered rising/falling edge detector; pulses lag the input change by one edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
            fall <= ~d & d_q;
        end
    end

endmodule

// File: rtl/motion_bbox_extract.sv
// Per-frame motion bounding box: tracks col/row over the 1-bit mask stream and
// publishes min/max X/Y, pixel count and a noise-gated valid at each vsync rise.
module motion_bbox_extract
    import motion_bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int CNT_W = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic             per_img_Bit,
    input  logic [CNT_W-1:0] Min_Pixel_Cnt,
    output logic [X_W-1:0]   box_x_min,
    output logic [X_W-1:0]   box_x_max,
    output logic [Y_W-1:0]   box_y_min,
    output logic [Y_W-1:0]   box_y_max,
    output logic [CNT_W-1:0] box_pix_cnt,
    output logic             box_valid,
    output logic             box_update
);

    localparam logic [X_W-1:0] COL_LIM = X_W'(IMG_W);
    localparam logic [Y_W-1:0] ROW_LIM = Y_W'(IMG_H);
    localparam logic [X_W-1:0] X_MIN0  = X_W'(MIN_INIT);
    localparam logic [X_W-1:0] X_MAX0  = X_W'(MAX_INIT);
    localparam logic [Y_W-1:0] Y_MIN0  = Y_W'(MIN_INIT);
    localparam logic [Y_W-1:0] Y_MAX0  = Y_W'(MAX_INIT);

    state_t state, state_nxt;
    logic latch, clr;

    logic vs_rise, unused_vs_fall;
    logic unused_hr_rise, hr_fall;

    logic [X_W-1:0] col;
    logic [Y_W-1:0] row;
    logic pix, motion;

    logic ev_q;
    logic [X_W-1:0] ev_col;
    logic [Y_W-1:0] ev_row;

    logic [X_W-1:0] x_min, x_max;
    logic [Y_W-1:0] y_min, y_max;
    logic [CNT_W-1:0] cnt;
    logic found, valid;

    sync_edge_det u_vs_edge (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .d    (per_frame_vsync),
        .rise (vs_rise),
        .fall (unused_vs_fall)
    );

    sync_edge_det u_hr_edge (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .d    (per_frame_href),
        .rise (unused_hr_rise),
        .fall (hr_fall)
    );

    assign pix    = per_frame_href & per_frame_clken & ~per_frame_vsync;
    assign motion = pix & per_img_Bit & (col < COL_LIM) & (row < ROW_LIM);
    assign valid  = found & (cnt >= Min_Pixel_Cnt);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= WAIT_FRAME;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        clr       = 1'b0;
        unique case (state)
            WAIT_FRAME: begin
                if (vs_rise) begin
                    state_nxt = ACCUM;
                    clr       = 1'b1;
                end
            end
            ACCUM: begin
                if (vs_rise) begin
                    latch = 1'b1;
                    clr   = 1'b1;
                end
            end
            default: state_nxt = WAIT_FRAME;
        endcase
    end

    // Line ends seen while vsync is high belong to blanking and do not advance rows.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || vs_rise) begin
            col <= '0;
            row <= '0;
        end else begin
            if (hr_fall)
                col <= '0;
            else if (pix && col != '1)
                col <= col + 1'b1;
            if (hr_fall && !per_frame_vsync && row != '1)
                row <= row + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ev_q   <= 1'b0;
            ev_col <= '0;
            ev_row <= '0;
        end else begin
            ev_q   <= motion;
            ev_col <= col;
            ev_row <= row;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            x_min <= X_MIN0;
            x_max <= X_MAX0;
            y_min <= Y_MIN0;
            y_max <= Y_MAX0;
            cnt   <= '0;
            found <= 1'b0;
        end else if (ev_q && state == ACCUM) begin
            if (ev_col < x_min) x_min <= ev_col;
            if (ev_col > x_max) x_max <= ev_col;
            if (ev_row < y_min) y_min <= ev_row;
            if (ev_row > y_max) y_max <= ev_row;
            if (cnt != '1)      cnt   <= cnt + 1'b1;
            found <= 1'b1;
        end
    end

    // A noise-gated frame still reports its true count, but no box.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            box_x_min   <= '0;
            box_x_max   <= '0;
            box_y_min   <= '0;
            box_y_max   <= '0;
            box_pix_cnt <= '0;
            box_valid   <= 1'b0;
            box_update  <= 1'b0;
        end else begin
            box_update <= latch;
            if (latch) begin
                box_pix_cnt <= cnt;
                box_valid   <= valid;
                box_x_min   <= valid ? x_min : '0;
                box_x_max   <= valid ? x_max : '0;
                box_y_min   <= valid ? y_min : '0;
                box_y_max   <= valid ? y_max : '0;
            end
        end
    end

endmodule
